// File: rtl/demux_1_4_stream.sv
// rtl/demux_1_4_stream.sv - 1-to-4 valid/ready stream demux with a one-word buffer per lane.
// Optional per-lane handshake counters are enabled by DEMUX_CNT_EN.
module demux_1_4_stream #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_sel,
  output logic             y0_valid,
  output logic             y1_valid,
  output logic             y2_valid,
  output logic             y3_valid,
  input  logic             y0_ready,
  input  logic             y1_ready,
  input  logic             y2_ready,
  input  logic             y3_ready,
  output logic [W-1:0]     y0,
  output logic [W-1:0]     y1,
  output logic [W-1:0]     y2,
`ifdef DEMUX_CNT_EN
  output logic [W-1:0]     y3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`else
  output logic [W-1:0]     y3
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic [3:0]        lane_ready;
  logic [3:0]        valid_q, valid_d;
  logic [3:0][W-1:0] data_q, data_d;
  logic              in_fire;

  assign lane_ready = {y3_ready, y2_ready, y1_ready, y0_ready};

  // Only the addressed lane can stall the producer.
  assign in_ready = !valid_q[in_sel] || lane_ready[in_sel];
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < 4; k++) begin
      if (in_fire && (in_sel == 2'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end else if (valid_q[k] && lane_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign {y3_valid, y2_valid, y1_valid, y0_valid} = valid_q;
  assign y0 = data_q[0];
  assign y1 = data_q[1];
  assign y2 = data_q[2];
  assign y3 = data_q[3];

`ifdef DEMUX_CNT_EN
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (valid_q[k] && lane_ready[k]) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb/tb_demux_1_4_stream.sv - directed self-checking bench for demux_1_4_stream.
module tb_demux_1_4_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic       y0_valid, y1_valid, y2_valid, y3_valid;
  logic       y0_ready, y1_ready, y2_ready, y3_ready;
  logic [3:0] y0, y1, y2, y3;
`ifdef DEMUX_CNT_EN
  logic [1:0] cnt0, cnt1, cnt2, cnt3;
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0]  vld;
  logic [15:0] ydat;
  assign vld  = {y3_valid, y2_valid, y1_valid, y0_valid};
  assign ydat = {y3, y2, y1, y0};

  always #5 clk = ~clk;

  demux_1_4_stream #(.W(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .y0_valid(y0_valid), .y1_valid(y1_valid), .y2_valid(y2_valid), .y3_valid(y3_valid),
    .y0_ready(y0_ready), .y1_ready(y1_ready), .y2_ready(y2_ready), .y3_ready(y3_ready),
    .y0(y0), .y1(y1), .y2(y2),
`ifdef DEMUX_CNT_EN
    .y3(y3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`else
    .y3(y3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic [3:0] r);
    {y3_ready, y2_ready, y1_ready, y0_ready} = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
    set_ready(4'b0000);
    tick(); tick();
    total++; if (vld !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", vld); end
    total++; if (ydat !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", ydat); end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_data = 4'(9 - i);
      tick();
    end
    in_valid = 1'b0;
    total++; if (vld !== 4'b1111) begin bad++; $display("FAIL busy_valid got=%b exp=1111", vld); end
    total++; if (ydat !== 16'h6789) begin bad++; $display("FAIL busy_data got=%h exp=6789", ydat); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (vld !== 4'b0000) begin bad++; $display("FAIL async_rst_valid got=%b exp=0000", vld); end
    total++; if (ydat !== 16'h0000) begin bad++; $display("FAIL async_rst_data got=%h exp=0000", ydat); end
    tick();
    total++; if (vld !== 4'b0000) begin bad++; $display("FAIL held_rst_valid got=%b exp=0000", vld); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    in_sel = 2'd0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    set_ready(4'b1111);
  endtask

  task automatic test_single();
    set_ready(4'b1111);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hA;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (vld !== 4'b0100) begin bad++; $display("FAIL single_valid got=%b exp=0100", vld); end
    total++; if (y2 !== 4'hA) begin bad++; $display("FAIL single_y2 got=%h exp=a", y2); end
    tick();
    total++; if (vld !== 4'b0000) begin bad++; $display("FAIL single_drain got=%b exp=0000", vld); end
    total++; if (y2 !== 4'hA) begin bad++; $display("FAIL single_hold got=%h exp=a", y2); end
  endtask

  task automatic test_backpressure();
    set_ready(4'b1101);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h3;
    tick();
    in_data = 4'h5;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    total++; if (y1 !== 4'h3) begin bad++; $display("FAIL bp_y1 got=%h exp=3", y1); end
    tick();
    total++; if (y1 !== 4'h3 || y1_valid !== 1'b1) begin bad++; $display("FAIL bp_stall got=%h/%b exp=3/1", y1, y1_valid); end
    set_ready(4'b1111);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (y1 !== 4'h5 || y1_valid !== 1'b1) begin bad++; $display("FAIL bp_no_bubble got=%h/%b exp=5/1", y1, y1_valid); end
    tick();
    total++; if (vld !== 4'b0000) begin bad++; $display("FAIL bp_drain got=%b exp=0000", vld); end
  endtask

  task automatic test_independent();
    set_ready(4'b1110);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'hE;
    tick();
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ind_lane0_full got=%b exp=0", in_ready); end
    in_sel = 2'd3; in_data = 4'h7;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ind_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (vld !== 4'b1001) begin bad++; $display("FAIL ind_valid got=%b exp=1001", vld); end
    total++; if (y3 !== 4'h7 || y0 !== 4'hE) begin bad++; $display("FAIL ind_data got=%h/%h exp=7/e", y3, y0); end
    set_ready(4'b1111);
    tick();
    total++; if (vld !== 4'b0000) begin bad++; $display("FAIL ind_drain got=%b exp=0000", vld); end
  endtask

  task automatic test_back_to_back();
    set_ready(4'b0000);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_data = 4'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    total++; if (vld !== 4'b1111) begin bad++; $display("FAIL b2b_valid got=%b exp=1111", vld); end
    total++; if (ydat !== 16'h4321) begin bad++; $display("FAIL b2b_data got=%h exp=4321", ydat); end
    set_ready(4'b1111);
    tick();
    total++; if (vld !== 4'b0000) begin bad++; $display("FAIL b2b_drain got=%b exp=0000", vld); end
    total++; if (ydat !== 16'h4321) begin bad++; $display("FAIL b2b_hold got=%h exp=4321", ydat); end
  endtask

  task automatic test_throughput();
    logic [3:0] words [3] = '{4'hB, 4'hC, 4'hD};
    set_ready(4'b1111);
    in_valid = 1'b1; in_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i];
      tick();
      total++; if (y2 !== words[i] || y2_valid !== 1'b1) begin bad++; $display("FAIL thru_%0d got=%h/%b exp=%h/1", i, y2, y2_valid, words[i]); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (y2_valid !== 1'b0) begin bad++; $display("FAIL thru_end got=%b exp=0", y2_valid); end
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counter();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0; in_valid = 1'b0;
    #2;
    total++; if (cnt0 !== 2'd0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", cnt0); end
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(4'b1111);
    in_valid = 1'b1; in_sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'(i);
      tick();
      if (i >= 1) begin
        total++; if (cnt0 !== exp_cnt[i-1]) begin bad++; $display("FAIL cnt0_%0d got=%0d exp=%0d", i - 1, cnt0, exp_cnt[i-1]); end
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (cnt0 !== exp_cnt[4]) begin bad++; $display("FAIL cnt0_4 got=%0d exp=%0d", cnt0, exp_cnt[4]); end
    total++; if ({cnt3, cnt2, cnt1} !== 6'd0) begin bad++; $display("FAIL cnt_others got=%0d/%0d/%0d exp=0/0/0", cnt1, cnt2, cnt3); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_independent();
    test_back_to_back();
    test_throughput();
`ifdef DEMUX_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
